// File: rtl/tff_counter_if.sv
// Signal bundle for tff_counter: control/load inputs and count/status outputs.
// master drives the controls and observes the count; slave is the counter.
interface tff_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, d,
        input  q, qb, tc, wrap
    );

    modport slave (
        input  en, up, load, d,
        output q, qb, tc, wrap
    );
endinterface

// File: rtl/tff_counter.sv
// tff_counter: WIDTH-bit up/down modulo counter whose state bits are T flip-flops.
// Each bit toggles when t[i] = q[i] ^ next_count[i]. Supports parallel load
// (clamped to MODULUS-1), direction control, combinational terminal count and a
// registered one-cycle wrap pulse.
// Optional feature: define TFF_CNT_SAT_EN to saturate at the count limits
// instead of wrapping; wrap then pulses every cycle the counter is held there.
module tff_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    tff_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO      = '0;

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic [WIDTH-1:0] t;

    // Next-count selection: load beats enable; direction picks the boundary.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        next_count = q_r;
        next_wrap  = 1'b0;
        if (bus.load) begin
            next_count = (bus.d > MAX_COUNT) ? MAX_COUNT : bus.d;
        end else if (bus.en && bus.up) begin
            if (q_r == MAX_COUNT) begin
`ifdef TFF_CNT_SAT_EN
                next_count = q_r;
`else
                next_count = ZERO;
`endif
                next_wrap  = 1'b1;
            end else begin
                next_count = q_r + 1'b1;
            end
        end else if (bus.en) begin
            if (q_r == ZERO) begin
`ifdef TFF_CNT_SAT_EN
                next_count = q_r;
`else
                next_count = MAX_COUNT;
`endif
                next_wrap  = 1'b1;
            end else begin
                next_count = q_r - 1'b1;
            end
        end
    end

    // Toggle vector: a bit flips exactly where current and next count differ.
    assign t = q_r ^ next_count;

    // T flip-flop bank plus registered wrap pulse; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, regardless of statement order.
            q_r    <= q_r ^ t;
            wrap_r <= next_wrap;
        end
    end

    assign bus.q    = q_r;
    assign bus.qb   = ~q_r;
    assign bus.wrap = wrap_r;
    assign bus.tc   = bus.en & ~bus.load &
                      (bus.up ? (q_r == MAX_COUNT) : (q_r == ZERO));

endmodule

// File: tb/tb_tff_counter.sv
// Directed self-checking bench for tff_counter (WIDTH=4, MODULUS=10).
// Build with TFF_CNT_SAT_EN defined to exercise the saturating variant.
module tb_tff_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tff_counter_if #(.WIDTH(4)) bus ();

    tff_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef TFF_CNT_SAT_EN
    logic [3:0] up_q    [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    logic       up_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
`else
    logic [3:0] up_q    [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    logic       up_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
`endif

    initial begin
        bus.en   = 1'b0;
        bus.up   = 1'b1;
        bus.load = 1'b0;
        bus.d    = 4'h0;

        // Reset state
        #1;
        check("rst_q", bus.q, 4'h0);
        check("rst_qb", bus.qb, 4'hF);
        check("rst_wrap", bus.wrap, 1'b0);
        #10 rst = 1'b1;

        // Reset mid-count: count to 5 then assert reset between edges
        @(negedge clk);
        bus.en = 1'b1;
        bus.up = 1'b1;
        repeat (5) step();
        check("pre_rst_q", bus.q, 4'h5);
        #2 rst = 1'b0;
        #1;
        check("midrst_q", bus.q, 4'h0);
        check("midrst_qb", bus.qb, 4'hF);
        check("midrst_wrap", bus.wrap, 1'b0);
        repeat (2) step();
        check("rst_hold_q", bus.q, 4'h0);
        @(negedge clk);
        rst = 1'b1;

        // Up-count 12 cycles from 0
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("up_tc_%0d", i), bus.tc, (bus.q == 4'h9) ? 1'b1 : 1'b0);
            step();
            check($sformatf("up_q_%0d", i), bus.q, up_q[i]);
            check($sformatf("up_wrap_%0d", i), bus.wrap, up_wrap[i]);
        end

        // Down-count across zero
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.d    = 4'h1;
        step();
        check("dn_load_q", bus.q, 4'h1);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        bus.up   = 1'b0;
        #1;
        check("dn_tc_at1", bus.tc, 1'b0);
        step();
        check("dn_q0", bus.q, 4'h0);
        check("dn_wrap0", bus.wrap, 1'b0);
        #1;
        check("dn_tc_at0", bus.tc, 1'b1);
        step();
`ifdef TFF_CNT_SAT_EN
        check("dn_q_sat", bus.q, 4'h0);
        check("dn_wrap_sat", bus.wrap, 1'b1);
        step();
        check("dn_q_sat2", bus.q, 4'h0);
        check("dn_wrap_sat2", bus.wrap, 1'b1);
`else
        check("dn_q9", bus.q, 4'h9);
        check("dn_wrap9", bus.wrap, 1'b1);
        step();
        check("dn_q8", bus.q, 4'h8);
        check("dn_wrap8", bus.wrap, 1'b0);
`endif

        // Load priority and clamp
        bus.load = 1'b1;
        bus.en   = 1'b1;
        bus.up   = 1'b1;
        bus.d    = 4'hC;
        #1;
        check("ld_tc_pre", bus.tc, 1'b0);
        step();
        check("ld_clamp_q", bus.q, 4'h9);
        check("ld_wrap", bus.wrap, 1'b0);
        check("ld_tc", bus.tc, 1'b0);
        bus.d = 4'h3;
        step();
        check("ld3_q", bus.q, 4'h3);
        check("ld3_wrap", bus.wrap, 1'b0);

        // Direction flip and hold
        bus.load = 1'b0;
        step();
        check("dir_up_q", bus.q, 4'h4);
        bus.up = 1'b0;
        step();
        check("dir_dn_q", bus.q, 4'h3);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold_q_%0d", i), bus.q, 4'h3);
            check($sformatf("hold_qb_%0d", i), bus.qb, 4'hC);
            check($sformatf("hold_wrap_%0d", i), bus.wrap, 1'b0);
        end

`ifdef TFF_CNT_SAT_EN
        // Saturation at the top: held at 9 with wrap every held cycle
        bus.load = 1'b1;
        bus.d    = 4'h8;
        step();
        check("sat_load_q", bus.q, 4'h8);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        bus.up   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("sat_q_%0d", i), bus.q, 4'h9);
            check($sformatf("sat_wrap_%0d", i), bus.wrap, (i == 0) ? 1'b0 : 1'b1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
